// File: rtl/approx_dot_accumulator.sv
// rtl/approx_dot_accumulator.sv - streaming saturating dot-product accumulator; optional macro BIAS_COMP_EN
module approx_dot_accumulator #(
   parameter int                PROD_W  = 16,
   parameter int                VEC_LEN = 8,
   parameter int                ACC_W   = 19,
   parameter logic [PROD_W-1:0] BIAS    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_sat
);

   localparam int               CNT_W = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;
   localparam int               SUM_W = ACC_W + 2;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(VEC_LEN - 1);
   localparam logic [SUM_W-1:0] MAX   = {2'b00, {ACC_W{1'b1}}};

   typedef enum logic {S_ACC, S_STALL} state_t;

   state_t           state, state_next;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             sticky;
   logic [SUM_W-1:0] term;
   logic [SUM_W-1:0] sum_raw;
   logic [ACC_W-1:0] sum_sat;
   logic             add_ovf;
   logic             accept;
   logic             final_beat;
   logic             hold_full;

`ifdef BIAS_COMP_EN
   // Bias is added in the wide domain so a biased term can never wrap.
   assign term = SUM_W'(in_prod) + SUM_W'(BIAS);
`else
   assign term = SUM_W'(in_prod);
   if (BIAS > 0) begin : g_bias_ignored
   end
`endif

   // Two spare bits above ACC_W make the overflow test a plain compare.
   assign sum_raw    = SUM_W'(acc) + term;
   assign add_ovf    = (sum_raw > MAX);
   assign sum_sat    = add_ovf ? {ACC_W{1'b1}} : sum_raw[ACC_W-1:0];
   assign accept     = in_valid && in_ready;
   assign final_beat = (cnt == LAST);
   assign hold_full  = final_beat && out_valid && !out_ready;

   // State register: STALL only while a final beat waits on a held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_ACC;
      else        state <= state_next;
   end

   // Next state and in_ready; the final beat is refused until the held result drains.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         S_ACC: begin
            in_ready = !clr && !hold_full;
            if (!clr && hold_full) state_next = S_STALL;
         end
         S_STALL: begin
            in_ready = !clr && out_ready;
            if (clr || out_ready) state_next = S_ACC;
         end
         default: state_next = S_ACC;
      endcase
      if (!rst_n) in_ready = 1'b0;
   end

   // Accumulator, beat counter and per-vector sticky saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (clr || (accept && final_beat)) begin
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (accept) begin
         acc    <= sum_sat;
         cnt    <= cnt + 1'b1;
         sticky <= sticky | add_ovf;
      end
   end

   // One-entry result register; a final beat on the handshake edge reloads it with no gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_sat   <= 1'b0;
      end else if (accept && final_beat) begin
         out_valid <= 1'b1;
         out_sum   <= sum_sat;
         out_sat   <= sticky | add_ovf;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/approx_dot_accumulator.md
# approx_dot_accumulator

Streaming accumulator that sits directly downstream of the unsigned 8x8 approximate multipliers. It consumes one 16-bit product per accepted beat and sums each group of VEC_LEN consecutive products into one dot-product result. Results are presented on a valid/ready output port with a one-entry result register, so accumulation of the next vector overlaps with a held result.

## Interface
- PROD_W, 16, product width; matches the multiplier `z` output
- VEC_LEN, 8, products per result, 2..256
- ACC_W, 19, accumulator/result width, >= PROD_W
- BIAS, 0, unsigned PROD_W-bit per-product compensation constant; used only with BIAS_COMP_EN

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous abort of the partial vector
- in_valid  in  1  product available
- in_ready  out  1  accumulator can accept
- in_prod  in  PROD_W  multiplier product
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  dot-product result
- out_sat  out  1  result saturated

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Internal state: acc (ACC_W), cnt (0..VEC_LEN-1), result register, out_valid.
- FSM:
  - ACC: in_ready=1 unless clr=1. Accept of a non-final beat (cnt<VEC_LEN-1): acc += term, cnt++.
  - Final beat (cnt==VEC_LEN-1) accepted: result := acc+term, out_sat := sticky saturation, acc:=0, cnt:=0, out_valid:=1.
  - STALL: entered when out_valid=1, out_ready=0 and cnt==VEC_LEN-1; in_ready=0. Returns to ACC at the out_ready edge.
- term = in_prod zero-extended to ACC_W (plus BIAS, see Configuration).
- Saturation: any add exceeding 2^ACC_W-1 clamps acc to 2^ACC_W-1 and sets a sticky flag for that vector; flag cleared with acc.
- Output handshake: out_valid && out_ready at an edge clears out_valid, unless a final beat is accepted the same edge; then the result register loads the new sum and out_valid stays 1.
- In ACC state, non-final beats are accepted regardless of out_valid/out_ready.
- clr=1: acc:=0, cnt:=0, sticky flag cleared, in_ready=0 that cycle, in_valid ignored; out_valid/out_sum/out_sat untouched; the output handshake still completes normally.
- rst_n low (any time, mid-vector included): all state cleared immediately; partial sums and a held result are lost.

## Timing
- Reset values: in_ready=0 while rst_n=0, 1 in the first cycle after release; out_valid=0; out_sum=0; out_sat=0; state ACC.
- Latency: out_valid rises the cycle after the edge accepting the final beat (1 cycle).
- Throughput: one product per cycle sustained while out_ready=1.
- in_ready is combinational from state, cnt, out_valid, out_ready and clr. There is no path from in_valid to in_ready.
- out_sum/out_sat stable while out_valid=1 && out_ready=0.

## Configuration
- BIAS_COMP_EN defined: term = in_prod + BIAS, widened to ACC_W before the add. This compensates the mean negative error of the truncated-term multipliers. Saturation applies to the biased sum.
- Not defined: term = in_prod. The BIAS parameter is ignored and no adder is instantiated for it.

## Test plan
- Default params, out_ready=1, eight beats of 1000 back-to-back -> out_valid one cycle after the 8th accept, out_sum=8000, out_sat=0.
- out_ready=0, sixteen beats of 1 -> first result 8 held; 9th–15th beats accepted; in_ready=0 at the 16th until out_ready=1, then second result 8.
- Final beat of vector 2 accepted on the same edge as the vector-1 handshake -> out_valid stays 1, out_sum changes 8000->16000 with no gap.
- clr after three beats of 500, then eight beats of 2 -> single result 16; a pending result present during clr is preserved.
- ACC_W=17, eight beats of 65025 -> out_sum=131071, out_sat=1; the next vector of eight 1s -> 8, out_sat=0.
- BIAS_COMP_EN, BIAS=100, eight beats of 1000 -> out_sum=8800. rst_n pulsed low after four beats -> no output; a fresh vector then yields the correct sum.
